// File: rtl/pll_cfg_bank_if.sv
// Slow configuration pin bundle and status/control outputs of pll_cfg_bank.
// load/read are level pins; only their rising edge (sampled while busy=0) starts an operation.
interface pll_cfg_bank_if #(
   parameter int N     = 96,
   parameter int S     = 8,
   parameter int CNT_W = 4
);
   logic             s_in;
   logic             s_en;
   logic             load;
   logic             read;
   logic [S-1:0]     status_in;
   logic             s_out;
   logic [N-1:0]     cfg;
   logic             cfg_valid;
   logic             commit_err;
   logic             busy;
   logic [CNT_W-1:0] commit_cnt;
   logic [1:0]       dbg_state;

   modport master (
      output s_in, s_en, load, read, status_in,
      input  s_out, cfg, cfg_valid, commit_err, busy, commit_cnt, dbg_state
   );

   modport slave (
      input  s_in, s_en, load, read, status_in,
      output s_out, cfg, cfg_valid, commit_err, busy, commit_cnt, dbg_state
   );
endinterface

// File: rtl/pll_cfg_bank.sv
// Serial PLL/FLL config bank: scan chain, protected shadow register, status capture.
// Optional even-parity check on commit enabled by defining CFG_PARITY_EN.
module pll_cfg_bank #(
   parameter int             N         = 96,
   parameter int             S         = 8,
   parameter int             CNT_W     = 4,
   parameter logic [N-1:0]   RESET_VAL = '0
) (
   input  logic           clk_in,
   input  logic           reset,
   pll_cfg_bank_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CHECK   = 2'd1,
      COMMIT  = 2'd2,
      CAPTURE = 2'd3
   } state_e;

   state_e           state_q;
   logic [N-1:0]     sr_q;
   logic [N-1:0]     cfg_q;
   logic             cfg_valid_q;
   logic             commit_err_q;
   logic             ok_q;
   logic             load_q;
   logic             read_q;
   logic [CNT_W-1:0] cnt_q;

   logic             load_edge;
   logic             read_edge;
   logic             ok_d;
   logic [N-1:0]     cap_raw;
   logic [N-1:0]     cap_d;

   generate
      if (S < N) begin : g_cap_mix
         assign cap_raw = {cfg_q[N-1:S], bus.status_in};
      end else begin : g_cap_status
         assign cap_raw = bus.status_in;
      end
   endgenerate

   always_comb begin
      load_edge = bus.load & ~load_q;
      read_edge = bus.read & ~read_q;
      cap_d     = cap_raw;
`ifdef CFG_PARITY_EN
      // Top bit of the frame is an even-parity bit over the rest.
      ok_d       = ~(^sr_q);
      cap_d[N-1] = ^cap_raw[N-2:0];
`else
      ok_d       = 1'b1;
`endif
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q      <= IDLE;
         sr_q         <= '0;
         cfg_q        <= RESET_VAL;
         cfg_valid_q  <= 1'b0;
         commit_err_q <= 1'b0;
         ok_q         <= 1'b0;
         load_q       <= 1'b0;
         read_q       <= 1'b0;
         cnt_q        <= '0;
      end else begin
         load_q <= bus.load;
         read_q <= bus.read;
         case (state_q)
            IDLE: begin
               if (load_edge) begin
                  state_q <= CHECK;
               end else if (read_edge) begin
                  state_q <= CAPTURE;
               end else if (bus.s_en) begin
                  sr_q <= {sr_q[N-2:0], bus.s_in};
               end
            end
            CHECK: begin
               ok_q    <= ok_d;
               state_q <= COMMIT;
            end
            COMMIT: begin
               if (ok_q) begin
                  cfg_q        <= sr_q;
                  cfg_valid_q  <= 1'b1;
                  commit_err_q <= 1'b0;
                  cnt_q        <= cnt_q + CNT_W'(1);
               end else begin
                  commit_err_q <= 1'b1;
               end
               state_q <= IDLE;
            end
            CAPTURE: begin
               sr_q    <= cap_d;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.s_out      = sr_q[N-1];
   assign bus.cfg        = cfg_q;
   assign bus.cfg_valid  = cfg_valid_q;
   assign bus.commit_err = commit_err_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.commit_cnt = cnt_q;
   assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_pll_cfg_bank.sv
// Directed self-checking bench for pll_cfg_bank (N=96, S=8, CNT_W=4).
// Parity expectations follow CFG_PARITY_EN when the bench is built with it.
module tb_pll_cfg_bank;

   localparam logic [95:0] RV = {12{8'h81}};
   localparam logic [95:0] PA = {12{8'hA5}};
   localparam logic [95:0] PB = {12{8'h5A}};
   localparam logic [95:0] PC = 96'h1;
   localparam logic [95:0] PD = {1'b1, 94'b0, 1'b1};

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   logic [95:0] got;
   logic [95:0] exp_v;

   always #5 clk = ~clk;

   pll_cfg_bank_if #(.N(96), .S(8), .CNT_W(4)) bus ();

   pll_cfg_bank #(.N(96), .S(8), .CNT_W(4), .RESET_VAL(RV)) dut (
      .clk_in (clk),
      .reset  (reset),
      .bus    (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expd);
      checks++;
      assert (obs === expd) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expd);
      end
   endtask

   task automatic shift_in(input logic [95:0] v);
      for (int i = 95; i >= 0; i--) begin
         bus.s_en = 1'b1;
         bus.s_in = v[i];
         tick();
      end
      bus.s_en = 1'b0;
      bus.s_in = 1'b0;
   endtask

   task automatic shift_out(output logic [95:0] v);
      for (int i = 95; i >= 0; i--) begin
         v[i]     = bus.s_out;
         bus.s_en = 1'b1;
         bus.s_in = 1'b0;
         tick();
      end
      bus.s_en = 1'b0;
   endtask

   task automatic do_commit();
      bus.load = 1'b1;
      tick();
      tick();
      tick();
      bus.load = 1'b0;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      reset         = 1'b1;
      bus.s_in      = 1'b0;
      bus.s_en      = 1'b0;
      bus.load      = 1'b0;
      bus.read      = 1'b0;
      bus.status_in = 8'h00;
      tick();
      tick();
      reset = 1'b0;
      check("rst_cfg", bus.cfg, RV);
      check("rst_valid", 96'(bus.cfg_valid), 96'd0);
      check("rst_cnt", 96'(bus.commit_cnt), 96'd0);
      check("rst_sout", 96'(bus.s_out), 96'd0);
      check("rst_busy", 96'(bus.busy), 96'd0);

      // Shift pattern A and commit; check two-cycle latency
      shift_in(PA);
      check("shift_sout", 96'(bus.s_out), 96'd1);
      bus.load = 1'b1;
      tick();
      check("chk_busy", 96'(bus.busy), 96'd1);
      check("chk_cfg_old", bus.cfg, RV);
      tick();
      check("cmt_busy", 96'(bus.busy), 96'd1);
      check("cmt_cfg_old", bus.cfg, RV);
      tick();
      check("load_cfg", bus.cfg, PA);
      check("load_valid", 96'(bus.cfg_valid), 96'd1);
      check("load_cnt", 96'(bus.commit_cnt), 96'd1);
      check("load_idle", 96'(bus.busy), 96'd0);
      for (int i = 0; i < 20; i++) tick();
      check("held_cnt", 96'(bus.commit_cnt), 96'd1);
      check("held_busy", 96'(bus.busy), 96'd0);
      bus.load = 1'b0;
      tick();

      // Status capture and readback
      bus.status_in = 8'h3C;
      bus.read = 1'b1;
      tick();
      check("cap_busy", 96'(bus.busy), 96'd1);
      bus.read = 1'b0;
      tick();
      check("cap_done", 96'(bus.busy), 96'd0);
      exp_v = {PA[95:8], 8'h3C};
`ifdef CFG_PARITY_EN
      exp_v[95] = ^exp_v[94:0];
`endif
      shift_out(got);
      check("readback", got, exp_v);

      // Simultaneous load+read edges, then read edge during busy
      shift_in(PB);
      bus.load = 1'b1;
      bus.read = 1'b1;
      tick();
      check("sim_state", 96'(bus.dbg_state), 96'd1);
      bus.read = 1'b0;
      tick();
      bus.read = 1'b1;
      tick();
      check("sim_cfg", bus.cfg, PB);
      check("sim_idle", 96'(bus.dbg_state), 96'd0);
      bus.load = 1'b0;
      bus.read = 1'b0;
      tick();
      check("sim_cnt", 96'(bus.commit_cnt), 96'd2);
      shift_out(got);
      check("sim_sr", got, PB);

      // Odd-parity frame then even-parity frame
      shift_in(PC);
      do_commit();
`ifdef CFG_PARITY_EN
      check("odd_cfg", bus.cfg, PB);
      check("odd_err", 96'(bus.commit_err), 96'd1);
      check("odd_cnt", 96'(bus.commit_cnt), 96'd2);
`else
      check("odd_cfg", bus.cfg, PC);
      check("odd_err", 96'(bus.commit_err), 96'd0);
      check("odd_cnt", 96'(bus.commit_cnt), 96'd3);
`endif
      shift_in(PD);
      do_commit();
      check("even_cfg", bus.cfg, PD);
      check("even_err", 96'(bus.commit_err), 96'd0);
`ifdef CFG_PARITY_EN
      check("even_cnt", 96'(bus.commit_cnt), 96'd3);
`else
      check("even_cnt", 96'(bus.commit_cnt), 96'd4);
`endif

      // Reset during the CHECK cycle of a commit
      shift_in(PA);
      bus.load = 1'b1;
      tick();
      check("pre_rst_state", 96'(bus.dbg_state), 96'd1);
      reset = 1'b1;
      bus.load = 1'b0;
      tick();
      reset = 1'b0;
      check("mid_rst_cfg", bus.cfg, RV);
      check("mid_rst_state", 96'(bus.dbg_state), 96'd0);
      check("mid_rst_valid", 96'(bus.cfg_valid), 96'd0);
      check("mid_rst_cnt", 96'(bus.commit_cnt), 96'd0);
      check("mid_rst_sout", 96'(bus.s_out), 96'd0);
      tick();
      tick();
      tick();
      check("post_rst_cfg", bus.cfg, RV);

      // Counter wrap after 16 good commits of the cleared chain
      for (int k = 0; k < 15; k++) do_commit();
      check("cnt_15", 96'(bus.commit_cnt), 96'd15);
      do_commit();
      check("cnt_wrap", 96'(bus.commit_cnt), 96'd0);
      check("wrap_valid", 96'(bus.cfg_valid), 96'd1);
      check("wrap_cfg", bus.cfg, 96'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pll_cfg_bank.md
Name: pll_cfg_bank

Overview:
Parametrised serial configuration bank for the PLL/FLL macro. It replaces the single combined shift/active register with three parts:
- a scan shift chain,
- a protected shadow (active) register that updates only on a validated commit,
- a status capture path for readback.

It sits between the external slow config pins (s_in, s_en, load, read) and the FLL/VCO control fields (dac, corner, slope_ctrl, vbias*), which are sliced from cfg.

Parameters:
N, 96, scan chain and cfg width in bits (N >= 2)
S, 8, status width captured on readback (1 <= S <= N)
CNT_W, 4, commit counter width
RESET_VAL, {N{1'b0}}, value of cfg after reset

Ports:
clk_in  input  1  single system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
s_in  input  1  serial data in, MSB first
s_en  input  1  shift enable (level)
load  input  1  commit request; acted on at rising edge
read  input  1  capture request; acted on at rising edge
status_in  input  S  live status (lock, corner_tmp, ...) sampled on capture
s_out  output  1  serial data out = sr[N-1] (registered)
cfg  output  N  active configuration
cfg_valid  output  1  1 after the first successful commit
commit_err  output  1  sticky; set on a rejected commit, cleared by the next good commit
busy  output  1  1 while FSM is not IDLE
commit_cnt  output  CNT_W  number of good commits, wraps modulo 2^CNT_W

Behaviour:
Reset (synchronous, reset=1 at clock edge):
- sr=0, cfg=RESET_VAL, cfg_valid=0, commit_err=0, commit_cnt=0, FSM=IDLE, edge-detect regs=0.
- Reset overrides everything, including a commit in flight; cfg then reads RESET_VAL.

Edge detection:
- load_q and read_q are registered every cycle, including while busy.
- Edge = input & ~q.
- A held-high level never retriggers.
- An edge arriving while busy=1 is dropped.

Priority in IDLE: load edge > read edge > s_en. Simultaneous load and read edges → commit only; the read is dropped.

FSM states:
- IDLE:
  - s_en=1 → sr <= {sr[N-2:0], s_in}.
  - load edge → CHECK.
  - read edge → CAPTURE.
  - busy=0.
- CHECK (1 cycle): evaluate validity of sr (see Optional Feature) into an internal ok flag. sr frozen; s_en ignored. → COMMIT.
- COMMIT (1 cycle):
  - ok=1 → cfg <= sr; cfg_valid <= 1; commit_err <= 0; commit_cnt <= commit_cnt+1 (wraps).
  - ok=0 → cfg unchanged; commit_err <= 1.
  - → IDLE.
- CAPTURE (1 cycle): sr <= {cfg[N-1:S], status_in}. → IDLE.
  - The following N shifts stream cfg MSBs then status to s_out.
  - Shifted-in s_in bits fill from the LSB.

Timing and latency:
- Load edge seen at cycle t → cfg updates at edge t+2; busy=1 during t+1..t+2.
- Read edge seen at cycle t → sr valid at t+1; busy=1 for 1 cycle.
- s_out always equals the current sr[N-1]; no extra delay.
- cfg is glitch-free and changes only in COMMIT or reset.

Optional Feature:
CFG_PARITY_EN
- Defined:
  - sr[N-1] is an even-parity bit over sr[N-2:0]; ok = (^sr == 0).
  - Odd parity → commit rejected and commit_err set.
  - cfg still receives the full N bits, parity bit included.
  - In CAPTURE, sr[N-1] is replaced by the parity of the captured sr[N-2:0] so readback is self-consistent (requires S < N).
- Undefined: ok is constantly 1; commit_err is tied 0; CAPTURE is exactly as stated above.

Test Plan:
1. Reset with cfg dirty → cfg=RESET_VAL, cfg_valid=0, commit_cnt=0, s_out=0, busy=0.
2. Shift 96 bits 0xA5A5_..._A5A5 with s_en=1, then load 0→1 → cfg=pattern exactly 2 cycles later; cfg_valid=1; commit_cnt=1; load held high 20 cycles → no second commit.
3. After commit, status_in=8'h3C, read pulse, 96 shifts → s_out yields cfg[95:8] then 0x3C, MSB first.
4. load and read rising in the same cycle → commit occurs, sr not overwritten by status; read pulse during busy → ignored.
5. With CFG_PARITY_EN, shift a payload with odd total parity, then load → cfg unchanged, commit_err=1, commit_cnt unchanged. Then a correct-parity frame → cfg updated, commit_err=0.
6. Reset asserted in the CHECK cycle of a commit → cfg=RESET_VAL, FSM=IDLE. Also: 16 good commits with CNT_W=4 → commit_cnt wraps to 0.
